// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle control FSM: state codes, opcode/funct
// constants, datapath mux select encodings and the ID dispatch function.
package mc_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    StIf  = 4'd0,
    StId  = 4'd1,
    StMa  = 4'd2,
    StMr  = 4'd3,
    StMw  = 4'd4,
    StMs  = 4'd5,
    StExr = 4'd6,
    StWbr = 4'd7,
    StBr  = 4'd8,
    StExi = 4'd9,
    StWbi = 4'd10,
    StJmp = 4'd11
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FnJr   = 6'b001000;
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnSlt  = 6'b101010;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;
  localparam logic [1:0] PcSrcRs     = 2'b11;

  localparam logic [1:0] WdAluOut = 2'b00;
  localparam logic [1:0] WdMdr    = 2'b01;
  localparam logic [1:0] WdPc     = 2'b10;
  localparam logic [1:0] WdLui    = 2'b11;

  localparam logic [1:0] RegDstRt = 2'b00;
  localparam logic [1:0] RegDstRd = 2'b01;
  localparam logic [1:0] RegDstRa = 2'b10;

  localparam logic [1:0] SrcbRt   = 2'b00;
  localparam logic [1:0] SrcbFour = 2'b01;
  localparam logic [1:0] SrcbImm  = 2'b10;
  localparam logic [1:0] SrcbBr   = 2'b11;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;
  localparam logic [1:0] AluOr    = 2'b11;

  // Successor of ID; StIf doubles as the "unsupported instruction" marker.
  function automatic state_e decode_next(logic [5:0] op, logic [5:0] funct);
    state_e nxt;
    nxt = StIf;
    case (op)
      OpLw, OpSw:              nxt = StMa;
      OpBeq, OpBne:            nxt = StBr;
      OpAddiu, OpOri, OpLui:   nxt = StExi;
      OpJ, OpJal:              nxt = StJmp;
      OpRtype: begin
        case (funct)
          FnAddu, FnSubu, FnAnd, FnOr, FnSlt: nxt = StExr;
          FnJr:                               nxt = StJmp;
          default:                            nxt = StIf;
        endcase
      end
      default:                 nxt = StIf;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational control decode: current state plus IR fields and ALU zero
// flag to every datapath control signal.
module mc_ctrl_outdec
  import mc_ctrl_fsm_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       last_dwell,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output logic       ext_op,
  output logic [1:0] alu_op,
  output logic       illegal
);

  // Per-state decode of all control outputs
  always_comb begin
    pc_write  = 1'b0;
    pc_src    = PcSrcAlu;
    iord      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    reg_dst   = RegDstRt;
    wd_sel    = WdAluOut;
    alu_srca  = 1'b0;
    alu_srcb  = SrcbRt;
    ext_op    = 1'b1;
    alu_op    = AluAdd;
    illegal   = 1'b0;
    unique case (state)
      StIf: begin
        mem_read = 1'b1;
        alu_srcb = SrcbFour;
        // PC+4 and IR commit together once the fetch data is valid
        ir_write = last_dwell;
        pc_write = last_dwell;
      end
      StId: begin
        alu_srcb = SrcbBr;
        illegal  = (decode_next(op, funct) == StIf);
      end
      StMa: begin
        alu_srca = 1'b1;
        alu_srcb = SrcbImm;
      end
      StMr: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      StMw: begin
        reg_write = 1'b1;
        wd_sel    = WdMdr;
      end
      StMs: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      StExr: begin
        alu_srca = 1'b1;
        alu_op   = AluFunct;
      end
      StWbr: begin
        reg_write = 1'b1;
        reg_dst   = RegDstRd;
      end
      StBr: begin
        alu_srca = 1'b1;
        alu_op   = AluSub;
        pc_src   = PcSrcAluOut;
        pc_write = (op == OpBne) ? ~zero : zero;
      end
      StExi: begin
        alu_srca = 1'b1;
        alu_srcb = SrcbImm;
        ext_op   = (op == OpAddiu);
        alu_op   = (op == OpOri) ? AluOr : AluAdd;
      end
      StWbi: begin
        reg_write = 1'b1;
        wd_sel    = (op == OpLui) ? WdLui : WdAluOut;
      end
      StJmp: begin
        pc_write = 1'b1;
        pc_src   = (op == OpRtype) ? PcSrcRs : PcSrcJump;
        if (op == OpJal) begin
          reg_write = 1'b1;
          reg_dst   = RegDstRa;
          wd_sel    = WdPc;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control FSM: state register, memory dwell counter
// and next-state logic; output decode lives in mc_ctrl_outdec.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output logic       ext_op,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] LastCnt = 4'(MEM_LATENCY - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_dwell;

  logic raw_pc_write, raw_mem_read, raw_mem_write, raw_ir_write, raw_reg_write, raw_illegal;

  assign last_dwell = (cnt_q == LastCnt);

  // State register and dwell counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIf;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: IF/MR/MS wait out the memory latency, everything else is one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIf, StMr, StMs: begin
        if (last_dwell) begin
          cnt_d = 4'd0;
          unique case (state_q)
            StIf:    state_d = StId;
            StMr:    state_d = StMw;
            default: state_d = StIf;
          endcase
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StId:  state_d = decode_next(op, funct);
      StMa:  state_d = (op == OpSw) ? StMs : StMr;
      StExr: state_d = StWbr;
      StExi: state_d = StWbi;
      default: state_d = StIf;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state      (state_q),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .last_dwell (last_dwell),
    .pc_write   (raw_pc_write),
    .pc_src     (pc_src),
    .iord       (iord),
    .mem_read   (raw_mem_read),
    .mem_write  (raw_mem_write),
    .ir_write   (raw_ir_write),
    .reg_write  (raw_reg_write),
    .reg_dst    (reg_dst),
    .wd_sel     (wd_sel),
    .alu_srca   (alu_srca),
    .alu_srcb   (alu_srcb),
    .ext_op     (ext_op),
    .alu_op     (alu_op),
    .illegal    (raw_illegal)
  );

  // Strobes are gated by reset so nothing is written while rst is held low
  always_comb begin
    pc_write  = raw_pc_write & rst;
    mem_read  = raw_mem_read & rst;
    mem_write = raw_mem_write & rst;
    ir_write  = raw_ir_write & rst;
    reg_write = raw_reg_write & rst;
    illegal   = raw_illegal & rst;
    state     = state_q;
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-cycle expected control records are
// queued when an instruction is presented and compared as the FSM steps.
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       iord;
    logic [1:0] rd;
    logic [1:0] wd;
    logic [1:0] aluop;
    logic [1:0] srcb;
    logic       ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance a: MEM_LATENCY=1, instance b: MEM_LATENCY=3
  logic [5:0] op_a = 6'd0, funct_a = 6'd0, op_b = 6'd0, funct_b = 6'd0;
  logic       zero_a = 1'b0, zero_b = 1'b0;
  logic       pcw_a, iord_a, mr_a, mw_a, irw_a, rw_a, srca_a, ext_a, ill_a;
  logic [1:0] pcs_a, rd_a, wd_a, srcb_a, aluop_a;
  logic [3:0] st_a;
  logic       pcw_b, iord_b, mr_b, mw_b, irw_b, rw_b, srca_b, ext_b, ill_b;
  logic [1:0] pcs_b, rd_b, wd_b, srcb_b, aluop_b;
  logic [3:0] st_b;

  mc_ctrl_fsm #(.MEM_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .op(op_a), .funct(funct_a), .zero(zero_a),
    .pc_write(pcw_a), .pc_src(pcs_a), .iord(iord_a), .mem_read(mr_a), .mem_write(mw_a),
    .ir_write(irw_a), .reg_write(rw_a), .reg_dst(rd_a), .wd_sel(wd_a), .alu_srca(srca_a),
    .alu_srcb(srcb_a), .ext_op(ext_a), .alu_op(aluop_a), .illegal(ill_a), .state(st_a)
  );

  mc_ctrl_fsm #(.MEM_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .op(op_b), .funct(funct_b), .zero(zero_b),
    .pc_write(pcw_b), .pc_src(pcs_b), .iord(iord_b), .mem_read(mr_b), .mem_write(mw_b),
    .ir_write(irw_b), .reg_write(rw_b), .reg_dst(rd_b), .wd_sel(wd_b), .alu_srca(srca_b),
    .alu_srcb(srcb_b), .ext_op(ext_b), .alu_op(aluop_b), .illegal(ill_b), .state(st_b)
  );

  exp_t obs_a, obs_b;
  assign obs_a = '{st: st_a, pcw: pcw_a, pcs: pcs_a, irw: irw_a, rw: rw_a, mr: mr_a, mw: mw_a,
                   iord: iord_a, rd: rd_a, wd: wd_a, aluop: aluop_a, srcb: srcb_a, ill: ill_a};
  assign obs_b = '{st: st_b, pcw: pcw_b, pcs: pcs_b, irw: irw_b, rw: rw_b, mr: mr_b, mw: mw_b,
                   iord: iord_b, rd: rd_b, wd: wd_b, aluop: aluop_b, srcb: srcb_b, ill: ill_b};

  exp_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string tag;

  function automatic exp_t blank(logic [3:0] st);
    exp_t e;
    e    = '0;
    e.st = st;
    return e;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, written from the ISA description
  task automatic push_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int lat);
    exp_t e;
    for (int i = 0; i < lat; i++) begin
      e = blank(4'd0); e.mr = 1'b1; e.srcb = 2'b01;
      e.irw = (i == lat - 1); e.pcw = (i == lat - 1);
      sb.push_back(e);
    end
    e = blank(4'd1); e.srcb = 2'b11;
    case (o)
      6'b100011: begin  // lw
        sb.push_back(e);
        e = blank(4'd2); e.srcb = 2'b10; sb.push_back(e);
        for (int i = 0; i < lat; i++) begin
          e = blank(4'd3); e.mr = 1'b1; e.iord = 1'b1; sb.push_back(e);
        end
        e = blank(4'd4); e.rw = 1'b1; e.wd = 2'b01; sb.push_back(e);
      end
      6'b101011: begin  // sw
        sb.push_back(e);
        e = blank(4'd2); e.srcb = 2'b10; sb.push_back(e);
        for (int i = 0; i < lat; i++) begin
          e = blank(4'd5); e.mw = 1'b1; e.iord = 1'b1; sb.push_back(e);
        end
      end
      6'b000000: begin
        if (f inside {6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010}) begin
          sb.push_back(e);
          e = blank(4'd6); e.aluop = 2'b10; sb.push_back(e);
          e = blank(4'd7); e.rw = 1'b1; e.rd = 2'b01; sb.push_back(e);
        end else if (f == 6'b001000) begin
          sb.push_back(e);
          e = blank(4'd11); e.pcw = 1'b1; e.pcs = 2'b11; sb.push_back(e);
        end else begin
          e.ill = 1'b1; sb.push_back(e);
        end
      end
      6'b000100, 6'b000101: begin
        sb.push_back(e);
        e = blank(4'd8); e.aluop = 2'b01; e.pcs = 2'b01;
        e.pcw = (o == 6'b000100) ? z : ~z;
        sb.push_back(e);
      end
      6'b001001, 6'b001101, 6'b001111: begin
        sb.push_back(e);
        e = blank(4'd9); e.srcb = 2'b10; e.aluop = (o == 6'b001101) ? 2'b11 : 2'b00;
        sb.push_back(e);
        e = blank(4'd10); e.rw = 1'b1; e.wd = (o == 6'b001111) ? 2'b11 : 2'b00;
        sb.push_back(e);
      end
      6'b000010, 6'b000011: begin
        sb.push_back(e);
        e = blank(4'd11); e.pcw = 1'b1; e.pcs = 2'b10;
        if (o == 6'b000011) begin e.rw = 1'b1; e.rd = 2'b10; e.wd = 2'b10; end
        sb.push_back(e);
      end
      default: begin
        e.ill = 1'b1; sb.push_back(e);
      end
    endcase
  endtask

  task automatic check_bit(input string name, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b, expected %b", name, obs, exp);
    end
  endtask

  // Pops up to n records, one per clock, comparing at negedge+1
  task automatic drain(input int n, input bit use_b);
    exp_t e, o;
    for (int k = 0; k < n && sb.size() > 0; k++) begin
      #1;
      e = sb.pop_front();
      o = use_b ? obs_b : obs_a;
      n_tests++;
      assert (o === e) else begin
        n_fail++;
        $error("FAIL %s cycle %0d: got %h, expected %h", tag, k, o, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic run_a(input string t, input logic [5:0] o, input logic [5:0] f,
                       input logic z);
    tag = t; op_a = o; funct_a = f; zero_a = z;
    push_instr(o, f, z, 1);
    drain(sb.size(), 1'b0);
  endtask

  task automatic run_b(input string t, input logic [5:0] o, input logic [5:0] f);
    tag = t; op_b = o; funct_b = f; zero_b = 1'b0;
    push_instr(o, f, 1'b0, 3);
    drain(sb.size(), 1'b1);
  endtask

  initial begin
    exp_t rst_exp;
    // Reset held for 3 cycles
    op_a = 6'b100011;
    repeat (3) @(negedge clk);
    rst_exp = blank(4'd0); rst_exp.srcb = 2'b01;
    tag = "reset"; sb.push_back(rst_exp);
    drain(1, 1'b0);
    check_bit("reset_ir_write", irw_a, 1'b0);
    rst = 1'b1;

    run_a("lw",        6'b100011, 6'b000000, 1'b0);
    run_a("beq_z1",    6'b000100, 6'b000000, 1'b1);
    run_a("beq_z0",    6'b000100, 6'b000000, 1'b0);
    run_a("bne_z0",    6'b000101, 6'b000000, 1'b0);
    run_a("bne_z1",    6'b000101, 6'b000000, 1'b1);
    run_a("jr",        6'b000000, 6'b001000, 1'b0);
    run_a("jal",       6'b000011, 6'b000000, 1'b0);
    run_a("j",         6'b000010, 6'b000000, 1'b0);
    run_a("addu",      6'b000000, 6'b100001, 1'b0);
    run_a("slt",       6'b000000, 6'b101010, 1'b0);
    run_a("addiu",     6'b001001, 6'b000000, 1'b0);
    run_a("ori",       6'b001101, 6'b000000, 1'b0);
    run_a("lui",       6'b001111, 6'b000000, 1'b0);
    run_a("sw",        6'b101011, 6'b000000, 1'b0);
    run_a("ill_op",    6'b111111, 6'b000000, 1'b0);
    run_a("ill_funct", 6'b000000, 6'b000000, 1'b0);
    check_bit("ori_ext_zero", ext_a, 1'b1);  // back in IF: default sign-extend

    // Reset asserted while in MR: abort before the next edge
    tag = "lw_abort"; op_a = 6'b100011; funct_a = 6'b000000;
    push_instr(6'b100011, 6'b000000, 1'b0, 1);
    drain(3, 1'b0);
    sb.delete();
    #1;
    check_bit("in_mr", (st_a == 4'd3), 1'b1);
    check_bit("mr_mem_read", mr_a, 1'b1);
    #1 rst = 1'b0;
    #1;
    check_bit("abort_state_if", (st_a == 4'd0), 1'b1);
    check_bit("abort_mem_read", mr_a, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_bit("abort_no_mw", (st_a == 4'd0), 1'b1);
    check_bit("abort_no_reg_write", rw_a, 1'b0);
    rst = 1'b1;
    run_a("after_abort", 6'b000000, 6'b100100, 1'b0);

    // Realign both instances, then exercise MEM_LATENCY=3
    rst = 1'b0;
    op_b = 6'b101011;
    @(negedge clk);
    rst = 1'b1;
    run_b("sw_lat3", 6'b101011, 6'b000000);
    run_b("lw_lat3", 6'b100011, 6'b000000);
    run_b("addu_lat3", 6'b000000, 6'b100001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Backstop against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
